uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` transmitter between four byte requesters. It accepts one byte at a time from the winning requester and drives `uart_tx`'s `start`/`tx_data`. It waits for the frame to finish, then enforces a full stop-bit guard interval before the next frame. Without the guard, back-to-back starts would shorten the stop bit, because `ready` rises in the same cycle the stop bit begins. Sits between the CPU/debug byte sources and `uart_tx`, on the `clock_50M` domain.

## Interface
- `REQ_NUM`, 4, number of requesters (fixed; logic written for 4)
- `GAP_CYCLES`, 9'd434, guard cycles after `tx_ready` rises before the next start (one bit time at 115.2 kbaud)
- `clock_50M`  in  1  system clock, 50 MHz
- `n_rst`  in  1  asynchronous active-low reset
- `req`  in  4  per-requester byte request; level, held until acked
- `req_data`  in  32  packed bytes; requester i uses `req_data[8*i+7:8*i]`
- `ack`  out  4  one-cycle pulse: requester i's byte accepted
- `tx_start`  out  1  to `uart_tx.start`; one-cycle pulse
- `tx_data`  out  8  to `uart_tx.tx_data`; registered
- `tx_ready`  in  1  from `uart_tx.ready` (1 = idle)
- `grant_id`  out  2  index of the last granted requester
- `busy`  out  1  1 when the FSM is not in IDLE

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, with `tx_ready`=1 and `req`≠0:
  - Choose the first asserted `req` scanning from `(last_grant+1) mod 4` upward, wrapping.
  - On that edge, register `tx_data` ← the chosen byte, `tx_start`←1, `ack[i]`←1, `grant_id`←i, `last_grant`←i.
  - Go to WAIT_BUSY.
- IDLE, with `tx_ready`=0 (transmitter externally busy): stay in IDLE and grant nothing.
- WAIT_BUSY: `tx_start` and `ack` return to 0 next edge. Go to WAIT_DONE when `tx_ready`=0 is sampled.
- WAIT_DONE: when `tx_ready`=1 is sampled, load the gap counter with 0 and go to GAP.
- GAP: increment the counter. When the counter == `GAP_CYCLES`-1, go to IDLE. The gap is exactly `GAP_CYCLES` cycles.
- Gap counter is 9 bits; `GAP_CYCLES`=0 is illegal.
- Round-robin pointer:
  - `last_grant` resets to 3, so requester 0 wins the first arbitration.
  - The pointer moves only on a grant.
  - A requester that keeps `req` high cannot win twice in a row if any other requester is pending.
- Requester protocol:
  - Hold `req` and the byte stable until the `ack` cycle.
  - `req` still high on the cycle after `ack` is treated as a new request for the next byte.
  - Deasserting `req` before `ack` withdraws the request; there is no error.
- `tx_data` holds its value until the next grant.
- `busy` = (state != IDLE).

## Timing
- Reset values: `tx_start`=0, `ack`=4'b0, `tx_data`=8'h00, `grant_id`=2'd0, `busy`=0, state IDLE, `last_grant`=3, gap counter 0.
- Request-to-start latency: `req` sampled high in IDLE at edge k → `tx_start`/`ack` high during cycle k..k+1. This is 1 cycle, and both are registered.
- `uart_tx` sees `start` at edge k+1 and drops `ready` after that edge. WAIT_BUSY exits at edge k+2.
- Frame spacing: start bit of the next frame begins no earlier than `GAP_CYCLES`+1 cycles after `tx_ready` rises. This guarantees a stop bit of at least one bit time.
- Simultaneous requests: resolved in a single arbitration in round-robin order. There is no starvation; worst-case wait is 3 frames plus gaps.
- A new `req` during WAIT_BUSY, WAIT_DONE, or GAP is queued at the requester, not sampled.
- Reset mid-operation (any state): all outputs return to reset values asynchronously. No `ack` is issued for an in-flight request. `uart_tx` shares `n_rst`.

## Test plan
- Single request: `req`=4'b0001, byte 8'hA5, with real `uart_tx` → one `ack[0]` pulse coincident with `tx_start`. The `tx` line carries 0, 1,0,1,0,0,1,0,1, then 1. `busy` falls 434 cycles after `ready` rises.
- All four requesting bytes 8'h10..8'h13 at once → grants in order 0,1,2,3; exactly one `ack` per requester; four frames on `tx`.
- Fairness: `req[0]` and `req[2]` held continuously → `grant_id` sequence 0,2,0,2,…; never the same requester twice in a row.
- Guard gap: bench with `GAP_CYCLES`=4 and a stub `tx_ready`:
  - Measure the cycles from `tx_ready` rising to the next `tx_start`; the result must be 5.
  - Hold `tx_ready` at 0 in IDLE; no `tx_start` may occur.
- Withdrawn request: `req[1]` pulsed for 1 cycle while in GAP → no `ack[1]` and no frame.
- Reset mid-frame: assert `n_rst`=0 during WAIT_DONE → outputs at reset values immediately. After release, `req`=4'b1000 is granted with `grant_id`=3 within 1 cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that lets four byte requesters
// share one uart_tx. It accepts one byte per frame and drives start/tx_data.
// After each frame it holds off for a stop-bit guard interval, so that
// back-to-back frames never shorten the stop bit.

module uart_tx_arbiter #(
    parameter int         REQ_NUM    = 4,
    parameter logic [8:0] GAP_CYCLES = 9'd434
) (
    input  logic                   clock_50M,
    input  logic                   n_rst,
    input  logic [REQ_NUM-1:0]     req,
    input  logic [8*REQ_NUM-1:0]   req_data,
    output logic [REQ_NUM-1:0]     ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [1:0]             grant_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [1:0]         last_grant;
    logic [8:0]         gap_cnt;

    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic [7:0]         pick_data;
    logic [REQ_NUM-1:0] pick_onehot;

    logic               grant_fire;
    logic               gap_load;
    logic               gap_step;
    logic               gap_last;

    // The guard interval ends on the cycle the counter reaches GAP_CYCLES-1.
    assign gap_last = (gap_cnt == (GAP_CYCLES - 9'd1));

    // Round-robin pick: scan upward from the requester after the last winner.
    // The last winner itself is checked last, so it only wins again when
    // nobody else is pending.
    always_comb begin
        logic [1:0] cand;
        pick_valid  = 1'b0;
        pick_idx    = last_grant;
        cand        = last_grant;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_data   = req_data[{pick_idx, 3'b000} +: 8];
        pick_onehot = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    // State register.
    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A grant needs an idle transmitter. The frame is
    // tracked as ready falling and then rising. The gap then runs its
    // full length.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (tx_ready && pick_valid) begin
                    next_state = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: the strobes that drive the registered datapath, plus busy.
    always_comb begin
        grant_fire = 1'b0;
        gap_load   = 1'b0;
        gap_step   = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE:      grant_fire = tx_ready && pick_valid;
            WAIT_BUSY: ;
            WAIT_DONE: gap_load   = tx_ready;
            GAP:       gap_step   = !gap_last;
            default:   ;
        endcase
    end

    // Registered outputs and pointer. start/ack are single-cycle pulses.
    // tx_data and grant_id hold until the next grant.
    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            tx_start   <= 1'b0;
            ack        <= '0;
            tx_data    <= 8'h00;
            grant_id   <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            tx_start <= grant_fire;
            ack      <= grant_fire ? pick_onehot : '0;
            if (grant_fire) begin
                tx_data    <= pick_data;
                grant_id   <= pick_idx;
                last_grant <= pick_idx;
            end
        end
    end

    // Guard-interval counter: cleared when the frame ends, then counts up
    // through the gap.
    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            gap_cnt <= 9'd0;
        end else if (gap_load) begin
            gap_cnt <= 9'd0;
        end else if (gap_step) begin
            gap_cnt <= gap_cnt + 9'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. The DUT runs with a short guard gap.
// A stub stands in for uart_tx's ready line. Each grant is checked
// against a scoreboard of expected (requester, byte) pairs.

module tb_uart_tx_arbiter;

    localparam logic [8:0] GAP   = 9'd4;
    localparam int         FRAME = 10;

    logic        clock_50M;
    logic        n_rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;

    logic        stub_ready;
    logic        hold_low;
    int          frame_cnt;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          cyc           = 0;
    int          start_count   = 0;
    int          ack1_count    = 0;
    logic        prev_ready    = 1'b1;
    logic        valid_rise    = 1'b0;
    int          rise_edge     = 0;
    logic        gap_meas      = 1'b0;

    uart_tx_arbiter #(.REQ_NUM(4), .GAP_CYCLES(GAP)) dut (
        .clock_50M (clock_50M),
        .n_rst     (n_rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // 50 MHz clock.
    initial clock_50M = 1'b0;
    always #10 clock_50M = ~clock_50M;

    // Posedge counter used for latency measurements.
    always @(posedge clock_50M) cyc <= cyc + 1;

    // Stub of uart_tx's ready line. Ready drops after the edge that sees
    // start and stays low for FRAME cycles. hold_low forces it busy from
    // outside.
    always @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            stub_ready <= 1'b1;
            frame_cnt  <= 0;
        end else if (tx_start) begin
            stub_ready <= 1'b0;
            frame_cnt  <= FRAME;
        end else if (frame_cnt != 0) begin
            frame_cnt <= frame_cnt - 1;
            if (frame_cnt == 1) stub_ready <= 1'b1;
        end
    end
    assign tx_ready = stub_ready && !hold_low;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total = checks_total + 1;
        if (act === exp) checks_passed = checks_passed + 1;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: whenever the DUT presents a grant, pop the scoreboard and
    // compare. With gap_meas set, it also checks the number of edges from
    // the first edge that samples ready high to the edge that launches start.
    always @(negedge clock_50M) begin
        exp_t e;
        if (tx_start || ack != 4'b0) begin
            start_count <= start_count + 1;
            if (ack[1]) ack1_count <= ack1_count + 1;
            if (exp_q.size() == 0) begin
                check_output("unexpected_grant", {28'b0, ack}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check_output("ack_onehot", {28'b0, ack}, 32'(4'b0001 << e.id));
                check_output("tx_start_with_ack", {31'b0, tx_start}, 32'h1);
                check_output("grant_id", {30'b0, grant_id}, {30'b0, e.id});
                check_output("tx_data", {24'b0, tx_data}, {24'b0, e.data});
            end
            if (gap_meas && valid_rise)
                check_output("gap_edges", 32'(cyc - rise_edge), 32'(GAP) + 32'd1);
            valid_rise <= 1'b0;
        end else if (tx_ready && !prev_ready) begin
            valid_rise <= 1'b1;
            rise_edge  <= cyc + 1;
        end
        prev_ready <= tx_ready;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(negedge clock_50M);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input logic [31:0] d);
        req      = r;
        req_data = d;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int idx, input string name);
        int n = 0;
        while (!ack[idx] && n < 200) begin
            step();
            n++;
        end
        if (!ack[idx]) check_output(name, 32'h0, 32'h1);
    endtask

    task automatic wait_ready(input logic level, input string name);
        int n = 0;
        while (tx_ready !== level && n < 200) begin
            step();
            n++;
        end
        if (tx_ready !== level) check_output(name, {31'b0, tx_ready}, {31'b0, level});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (busy) check_output(name, 32'h1, 32'h0);
    endtask

    initial begin
        int n;
        int acks;
        int starts_before;
        int ack1_before;
        n_rst    = 1'b0;
        hold_low = 1'b0;
        apply_stimulus(4'b0000, 32'h0);

        // Reset state.
        repeat (3) step();
        check_output("rst_tx_start", {31'b0, tx_start}, 32'h0);
        check_output("rst_ack", {28'b0, ack}, 32'h0);
        check_output("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check_output("rst_grant_id", {30'b0, grant_id}, 32'h0);
        check_output("rst_busy", {31'b0, busy}, 32'h0);
        n_rst = 1'b1;
        step();

        // All four at once. Starting from last_grant=3, the order is
        // 0,1,2,3. Each requester drops its request on its own ack.
        push_exp(2'd0, 8'h10);
        push_exp(2'd1, 8'h11);
        push_exp(2'd2, 8'h12);
        push_exp(2'd3, 8'h13);
        apply_stimulus(4'b1111, 32'h13121110);
        n = 0;
        while (req != 4'b0 && n < 400) begin
            step();
            req = req & ~ack;
            n++;
        end
        check_output("all_four_done", {28'b0, req}, 32'h0);
        wait_idle("idle_after_all_four");

        // Single request 0xA5 on requester 0. While in GAP, requester 1
        // pulses for one cycle and must be ignored. Ready is seen high just
        // before edge r, and busy clears after edge r+GAP.
        push_exp(2'd0, 8'hA5);
        apply_stimulus(4'b0001, 32'h000000A5);
        wait_ack(0, "single_ack_timeout");
        req = 4'b0000;
        wait_ready(1'b0, "single_ready_low");
        wait_ready(1'b1, "single_ready_high");
        starts_before = start_count;
        ack1_before   = ack1_count;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
            if (n == 1) req = 4'b0010;
            if (n == 2) req = 4'b0000;
        end
        check_output("busy_fall_edges", 32'(n), 32'(GAP) + 32'd1);
        repeat (10) step();
        check_output("withdrawn_no_ack1", 32'(ack1_count), 32'(ack1_before));
        check_output("withdrawn_no_start", 32'(start_count), 32'(starts_before));

        // Fairness. Requesters 0 and 2 hold req; last_grant is 0, so the
        // order is 2,0,2,0. Every later start follows the guard gap exactly.
        push_exp(2'd2, 8'h22);
        push_exp(2'd0, 8'h20);
        push_exp(2'd2, 8'h22);
        push_exp(2'd0, 8'h20);
        apply_stimulus(4'b0101, 32'h00220020);
        acks = 0;
        n = 0;
        while (acks < 4 && n < 600) begin
            step();
            n++;
            if (ack != 4'b0) begin
                acks++;
                if (acks == 1) gap_meas = 1'b1;
                if (acks == 4) begin
                    req      = 4'b0000;
                    gap_meas = 1'b0;
                end
            end
        end
        check_output("fairness_acks", 32'(acks), 32'd4);
        wait_idle("idle_after_fairness");

        // Transmitter held busy from outside: no start may occur until
        // ready is released. The pending grant then goes to requester 1.
        hold_low = 1'b1;
        push_exp(2'd1, 8'h3C);
        apply_stimulus(4'b0010, 32'h00003C00);
        starts_before = start_count;
        repeat (20) step();
        check_output("held_ready_no_start", 32'(start_count), 32'(starts_before));
        hold_low = 1'b0;
        wait_ack(1, "held_release_ack_timeout");
        req = 4'b0000;
        wait_idle("idle_after_hold");

        // Reset during WAIT_DONE: outputs clear at once. After release,
        // requester 3 wins on the first edge.
        push_exp(2'd2, 8'h5C);
        apply_stimulus(4'b0100, 32'h005C0000);
        wait_ack(2, "pre_reset_ack_timeout");
        req = 4'b0000;
        wait_ready(1'b0, "pre_reset_ready_low");
        step();
        n_rst = 1'b0;
        #1;
        check_output("midrst_tx_data", {24'b0, tx_data}, 32'h0);
        check_output("midrst_grant_id", {30'b0, grant_id}, 32'h0);
        check_output("midrst_busy", {31'b0, busy}, 32'h0);
        check_output("midrst_ack", {28'b0, ack}, 32'h0);
        repeat (2) step();
        n_rst = 1'b1;
        push_exp(2'd3, 8'h77);
        apply_stimulus(4'b1000, 32'h77000000);
        step();
        check_output("post_rst_grant", {30'b0, grant_id}, 32'h3);
        check_output("post_rst_start", {31'b0, tx_start}, 32'h1);
        req = 4'b0000;
        wait_idle("idle_after_reset_test");
        repeat (3) step();

        check_output("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
